// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack fetch from instruction memory, field split, valid/ready output.
// Optional macro FETCH_INSTR_COUNT_EN adds a saturating consumed-instruction counter (instr_count).
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_instr,
    output logic [3:0]      out_opcode,
    output logic [1:0]      rs_addr,
    output logic [1:0]      rt_addr,
    output logic [3:0]      out_imm,
    output logic [PC_W-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [15:0]     instr_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_run;
    logic            r_stale;
    logic            r_halt_lat;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_out_pc;
    logic [7:0]      r_instr;
    logic [PC_W-1:0] w_pc_next;
    logic            w_stale_next;
    logic            w_issue;
    logic            w_capture;
    logic            w_consume;

    // r_run holds off the first request until the cycle after reset is released
    assign w_issue   = r_run && (r_state == S_REQ);
    assign w_capture = (r_state == S_WAIT) && imem_ack && !r_stale && !redirect_valid;
    assign w_consume = (r_state == S_OUT) && out_ready;

    // Next-state, next-PC and stale-fetch tracking
    always_comb begin
        w_next       = r_state;
        w_pc_next    = r_pc;
        w_stale_next = r_stale;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_next = redirect_pc;
                    // a request going out this very cycle already targets the old PC
                    if (w_issue) begin
                        w_next       = S_WAIT;
                        w_stale_next = 1'b1;
                    end else begin
                        w_next = S_REQ;
                    end
                end else if (w_issue) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_stale_next = 1'b0;
                    if (redirect_valid) begin
                        w_pc_next = redirect_pc;
                        w_next    = S_REQ;
                    end else if (r_stale) begin
                        w_next = S_REQ;
                    end else begin
                        w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                        w_next    = S_OUT;
                    end
                end else if (redirect_valid) begin
                    w_pc_next    = redirect_pc;
                    w_stale_next = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_pc_next = redirect_pc;
                    w_next    = S_REQ;
                end else if (out_ready) begin
                    w_next = (halt || r_halt_lat) ? S_HALT : S_REQ;
                end else begin
                    w_next = S_OUT;
                end
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_REQ;
            end
        endcase
    end

    // State, PC and captured-instruction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_run      <= 1'b0;
            r_stale    <= 1'b0;
            r_halt_lat <= 1'b0;
            r_pc       <= RESET_PC;
            r_out_pc   <= RESET_PC;
            r_instr    <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_run      <= 1'b1;
            r_stale    <= w_stale_next;
            r_halt_lat <= r_halt_lat | halt;
            r_pc       <= w_pc_next;
            if (w_capture) begin
                r_instr  <= imem_rdata;
                r_out_pc <= r_pc;
            end
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    // Saturating count of consumed instructions; redirects do not clear it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_count <= 16'h0000;
        end else if (w_consume && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'h0001;
        end
    end

    assign instr_count = r_instr_count;
`else
    logic w_unused_consume;
    assign w_unused_consume = w_consume;
`endif

    assign imem_req   = w_issue;
    assign imem_addr  = r_pc;
    assign out_valid  = (r_state == S_OUT);
    assign out_instr  = r_instr;
    assign out_opcode = r_instr[7:4];
    assign rs_addr    = r_instr[3:2];
    assign rt_addr    = r_instr[1:0];
    assign out_imm    = r_instr[3:0];
    assign out_pc     = r_out_pc;
    assign halted     = (r_state == S_HALT);

endmodule
